// File: rtl/trojan_response_checker_pkg.sv
// trojan_chk_pkg: shared FSM states, default width and MISR constants for trojan_response_checker
package trojan_chk_pkg;
  typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;
  localparam int DEF_N_IN = 3;
  localparam logic [15:0] MISR_POLY = 16'h1021;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;
endpackage

// File: rtl/trojan_response_checker_if.sv
// trojan_response_checker_if: load/stimulus/result bundle; signature exists only with TROJAN_CHK_SIGNATURE_EN
interface trojan_response_checker_if #(parameter int N_IN = 3);
  logic            load_valid;
  logic [N_IN-1:0] load_addr;
  logic            load_data;
  logic            start;
  logic            vec_valid;
  logic [N_IN-1:0] vec_in;
  logic            dut_out;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   mismatch_cnt;
  logic            first_fail_valid;
  logic [N_IN-1:0] first_fail_vec;
  logic            cov_full;
`ifdef TROJAN_CHK_SIGNATURE_EN
  logic [15:0]     signature;
`endif
  modport master (
    output load_valid, load_addr, load_data, start, vec_valid, vec_in, dut_out,
    input  busy, done, pass, mismatch_cnt, first_fail_valid, first_fail_vec, cov_full
`ifdef TROJAN_CHK_SIGNATURE_EN
    , signature
`endif
  );
  modport slave (
    input  load_valid, load_addr, load_data, start, vec_valid, vec_in, dut_out,
    output busy, done, pass, mismatch_cnt, first_fail_valid, first_fail_vec, cov_full
`ifdef TROJAN_CHK_SIGNATURE_EN
    , signature
`endif
  );
endinterface

// File: rtl/trojan_response_checker_golden_table.sv
// trojan_golden_table: DEPTH x 1 expected-response table, sync write, comb read, async active-low clear
import trojan_chk_pkg::*;
module trojan_golden_table #(parameter int N_IN = DEF_N_IN) (
  input  logic            CK,
  input  logic            reset,
  input  logic            we,
  input  logic [N_IN-1:0] waddr,
  input  logic            wdata,
  input  logic [N_IN-1:0] raddr,
  output logic            rdata
);
  localparam int DEPTH = 2**N_IN;
  logic [DEPTH-1:0] mem;
  always_ff @(posedge CK or negedge reset)
    if (!reset) mem <= '0;
    else if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/trojan_response_checker.sv
// trojan_response_checker: compares (vector, response) pairs to a golden table and tracks coverage;
// optional MISR signature output under TROJAN_CHK_SIGNATURE_EN
import trojan_chk_pkg::*;
module trojan_response_checker #(parameter int N_IN = DEF_N_IN) (
  input logic CK,
  input logic reset,
  trojan_response_checker_if.slave bus
);
  localparam int DEPTH = 2**N_IN;
  localparam int CNT_W = N_IN + 1;
  state_t           state;
  logic [DEPTH-1:0] bitmap, bitmap_nxt;
  logic             gold, mism;
  logic [CNT_W-1:0] cnt_nxt;
  trojan_golden_table #(.N_IN(N_IN)) u_table (
    .CK    (CK),
    .reset (reset),
    .we    (bus.load_valid && state != CHECK),
    .waddr (bus.load_addr),
    .wdata (bus.load_data),
    .raddr (bus.vec_in),
    .rdata (gold)
  );
  assign mism       = bus.dut_out ^ gold;
  assign bitmap_nxt = bitmap | (DEPTH'(1) << bus.vec_in);
  assign cnt_nxt    = (mism && bus.mismatch_cnt != '1) ? bus.mismatch_cnt + 1'b1 : bus.mismatch_cnt;
  always_ff @(posedge CK or negedge reset)
    if (!reset) begin
      state                <= IDLE;
      bus.busy             <= 1'b0;
      bus.done             <= 1'b0;
      bus.pass             <= 1'b0;
      bus.mismatch_cnt     <= '0;
      bus.first_fail_valid <= 1'b0;
      bus.first_fail_vec   <= '0;
      bus.cov_full         <= 1'b0;
      bitmap               <= '0;
`ifdef TROJAN_CHK_SIGNATURE_EN
      bus.signature        <= MISR_SEED;
`endif
    end else if (state != CHECK) begin
      if (bus.start) begin
        state                <= CHECK;
        bus.busy             <= 1'b1;
        bus.done             <= 1'b0;
        bus.pass             <= 1'b0;
        bus.mismatch_cnt     <= '0;
        bus.first_fail_valid <= 1'b0;
        bus.first_fail_vec   <= '0;
        bus.cov_full         <= 1'b0;
        bitmap               <= '0;
`ifdef TROJAN_CHK_SIGNATURE_EN
        bus.signature        <= MISR_SEED;
`endif
      end
    end else if (bus.vec_valid) begin
      bitmap           <= bitmap_nxt;
      bus.mismatch_cnt <= cnt_nxt;
      if (mism && !bus.first_fail_valid) begin
        bus.first_fail_valid <= 1'b1;
        bus.first_fail_vec   <= bus.vec_in;
      end
`ifdef TROJAN_CHK_SIGNATURE_EN
      bus.signature <= {bus.signature[14:0], 1'b0} ^ (bus.signature[15] ? MISR_POLY : 16'h0)
                       ^ 16'({bus.vec_in, bus.dut_out});
`endif
      // coverage completes on the edge that samples the last unseen vector
      if (&bitmap_nxt) begin
        state        <= DONE;
        bus.busy     <= 1'b0;
        bus.done     <= 1'b1;
        bus.cov_full <= 1'b1;
        bus.pass     <= (cnt_nxt == '0);
      end
    end
endmodule
